mxu_job_sequencer: RTL
======================

Name: mxu_job_sequencer

Overview:
- Host-facing controller for the matrix multiply unit (mxu).
- Collects A/B operand bytes through a valid/ready write port into internal operand registers, launches the mxu, and waits for its done pulse with a watchdog.
- On done, sweeps the mxu read address over every accumulator and copies the results into a local result buffer.
- Sits between the host bus adapter and the mxu, owning all of the mxu control inputs.

Parameters:
- SIZE, 4, matrix dimension; the mxu array is SIZE x SIZE.
- RD_LAT, 1, cycles from driving mxu_araddr to mxu_rdata being valid (legal range 0..3).
- TIMEOUT, 1024, maximum WAIT cycles before an error is declared.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  host operand write request.
- wr_ready  out  1  write accepted when wr_valid&&wr_ready.
- wr_addr  in  8  0..SIZE*SIZE-1 selects A element (row-major); SIZE*SIZE..2*SIZE*SIZE-1 selects B element (row-major).
- wr_data  in  8  operand byte.
- cmd_start  in  1  single-cycle job start request.
- cfg_cycles  in  1  sampled on start acceptance; drives mxu_cycles for the job.
- busy  out  1  job in progress.
- done  out  1  sticky: last job completed.
- err  out  1  sticky: last job timed out.
- res_addr  in  $clog2(SIZE*SIZE)  result buffer read index.
- res_data  out  32  result buffer word; combinational read.
- mxu_start  out  1  to mxu start_in.
- mxu_cycles  out  1  to mxu cycles_in.
- mxu_a  out  SIZE*SIZE*8  to mxu data_a_in; element k at bits [8k+:8].
- mxu_b  out  SIZE*SIZE*8  to mxu data_b_in; same packing.
- mxu_done  in  1  from mxu done_o.
- mxu_araddr  out  32  to mxu araddr.
- mxu_rdata  in  32  from mxu rdata.

Behaviour:
- Reset (async): state IDLE; operand registers, result buffer and counters cleared to 0.
  - Outputs: wr_ready=1, busy=0, done=0, err=0, mxu_start=0, mxu_cycles=0, mxu_araddr=0.
- States: IDLE, LAUNCH, WAIT, DRAIN, FLUSH.
- IDLE:
  - wr_ready=1, busy=0.
  - An accepted write with wr_addr >= 2*SIZE*SIZE is acknowledged and dropped.
  - cmd_start: latch cfg_cycles, clear done and err, go to LAUNCH.
  - cmd_start and a write in the same cycle: the write lands first and is part of the job.
- LAUNCH: one cycle. mxu_start=1, busy=1, wr_ready=0. Next state is WAIT.
- WAIT:
  - Watchdog counter increments every cycle.
  - mxu_done=1 goes to DRAIN with element index e=0.
  - Counter reaching TIMEOUT-1 without done: err=1, go to IDLE, result buffer unchanged.
  - mxu_done seen during LAUNCH is also honoured: WAIT is skipped and the next state is DRAIN.
- DRAIN:
  - Each cycle drive mxu_araddr = e+1; the mxu internally selects araddr-1, so index SIZE*SIZE wraps correctly.
  - Increment e; SIZE*SIZE cycles total.
- Capture: a shift pipeline of depth RD_LAT tags each issued index. The result buffer word[tag] is written with mxu_rdata when the tag emerges.
- FLUSH: waits RD_LAT cycles until the pipeline is empty, then sets done=1, busy=0 and goes to IDLE. With RD_LAT=0, FLUSH lasts 0 cycles.
- mxu_araddr returns to 0 outside DRAIN.
- Latency: start accepted at cycle 0, mxu_start at cycle 1.
  - If mxu_done occurs at cycle D, done rises at D+1+SIZE*SIZE+RD_LAT.
- Other rules:
  - cmd_start outside IDLE is ignored.
  - wr_valid outside IDLE is held off (wr_ready=0); the operands stay stable for the whole job.
  - mxu_done outside LAUNCH/WAIT is ignored.
  - res_data is always readable. During DRAIN, words already captured show the new values; the rest show the prior job's values.
  - Reset mid-job aborts immediately to reset values.

Test Plan:
- Write A=identity, B[k]=k+1, start with a model mxu (done after 10 cycles, RD_LAT=1) -> mxu_start pulses 1 cycle; res_data[k]=k+1 for all 16; done rises exactly 1+16+1 cycles after mxu_done; busy low again.
- Sweep check -> mxu_araddr sequence 1,2,...,16 on consecutive cycles, then 0; wr_ready=0 throughout the job.
- mxu never asserts done, TIMEOUT=32 -> err=1 and busy=0 32 cycles after WAIT entry; done=0; result buffer unchanged; a subsequent start clears err.
- cmd_start in the same cycle as a write to addr 31 of value 0x7F -> mxu_b bits [127:120]=0x7F at launch; write to addr 40 is acknowledged, no register changes.
- Reset asserted mid-DRAIN -> all outputs return to reset values asynchronously; result buffer reads 0; a new job after deassertion completes normally.
- RD_LAT=0 and RD_LAT=3 builds -> every word lands at the correct index; done delay tracks RD_LAT.

Source files
------------

// File: rtl/mxu_job_sequencer_if.sv
// Host operand write channel into the mxu job sequencer (valid/ready, byte wide).
interface mxu_job_sequencer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/mxu_job_sequencer.sv
// Loads mxu operands, launches a job, watchdogs done, then sweeps accumulators into a result buffer.
// Done rises 1+SIZE*SIZE+RD_LAT cycles after mxu_done; host writes are held off (wr_ready=0) while busy.
module mxu_job_sequencer #(
  parameter int SIZE    = 4,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  mxu_job_sequencer_if.slave            wr,
  input  logic                          cmd_start,
  input  logic                          cfg_cycles,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  input  logic [$clog2(SIZE*SIZE)-1:0]  res_addr,
  output logic [31:0]                   res_data,
  output logic                          mxu_start,
  output logic                          mxu_cycles,
  output logic [SIZE*SIZE*8-1:0]        mxu_a,
  output logic [SIZE*SIZE*8-1:0]        mxu_b,
  input  logic                          mxu_done,
  output logic [31:0]                   mxu_araddr,
  input  logic [31:0]                   mxu_rdata
);
  localparam int N  = SIZE * SIZE;
  localparam int IW = $clog2(N);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DRAIN, FLUSH} state_t;

  state_t        state;
  logic [IW-1:0] elem;
  logic [WW-1:0] wdog;
  logic [1:0]    flush_cnt;
  logic          wr_rdy_q;
  logic          wr_fire;
  logic          cap_vld;
  logic [IW-1:0] cap_tag;
  logic [31:0]   res_mem [N];

  assign wr.wr_ready = wr_rdy_q;
  assign wr_fire     = wr.wr_valid && wr_rdy_q;

  // wr_ready is only high in IDLE, so operands cannot move under a running job.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mxu_a <= '0;
      mxu_b <= '0;
    end else if (wr_fire) begin
      if (wr.wr_addr < 8'(N))
        mxu_a[8*wr.wr_addr +: 8] <= wr.wr_data;
      else if (wr.wr_addr < 8'(2*N))
        mxu_b[8*(wr.wr_addr - 8'(N)) +: 8] <= wr.wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_rdy_q   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      mxu_start  <= 1'b0;
      mxu_cycles <= 1'b0;
      mxu_araddr <= '0;
      elem       <= '0;
      wdog       <= '0;
      flush_cnt  <= '0;
    end else begin
      mxu_start <= 1'b0;
      case (state)
        IDLE: if (cmd_start) begin
          mxu_cycles <= cfg_cycles;
          done       <= 1'b0;
          err        <= 1'b0;
          busy       <= 1'b1;
          wr_rdy_q   <= 1'b0;
          mxu_start  <= 1'b1;
          state      <= LAUNCH;
        end
        LAUNCH: begin
          wdog <= '0;
          if (mxu_done) begin
            elem       <= '0;
            mxu_araddr <= 32'd1;
            state      <= DRAIN;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          wdog <= wdog + 1'b1;
          if (mxu_done) begin
            elem       <= '0;
            mxu_araddr <= 32'd1;
            state      <= DRAIN;
          end else if (wdog == WW'(TIMEOUT - 1)) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            wr_rdy_q <= 1'b1;
            state    <= IDLE;
          end
        end
        DRAIN: begin
          elem <= elem + 1'b1;
          if (elem == IW'(N - 1)) begin
            mxu_araddr <= '0;
            flush_cnt  <= '0;
            if (RD_LAT == 0) begin
              done     <= 1'b1;
              busy     <= 1'b0;
              wr_rdy_q <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= FLUSH;
            end
          end else begin
            // mxu reads accumulator araddr-1, so the address leads the index by one
            mxu_araddr <= 32'(elem) + 32'd2;
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == 2'(RD_LAT - 1)) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            wr_rdy_q <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag pipeline matches the mxu read latency so each word lands at its own index.
  generate
    if (RD_LAT == 0) begin : g_nolat
      assign cap_vld = (state == DRAIN);
      assign cap_tag = elem;
    end else begin : g_lat
      logic [RD_LAT-1:0] vld_pipe;
      logic [IW-1:0]     tag_pipe [RD_LAT];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_pipe <= '0;
          for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
        end else begin
          vld_pipe[0] <= (state == DRAIN);
          tag_pipe[0] <= elem;
          for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            tag_pipe[i] <= tag_pipe[i-1];
          end
        end
      end
      assign cap_vld = vld_pipe[RD_LAT-1];
      assign cap_tag = tag_pipe[RD_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) res_mem[i] <= '0;
    end else if (cap_vld) begin
      res_mem[cap_tag] <= mxu_rdata;
    end
  end

  assign res_data = res_mem[res_addr];
endmodule
